// File: rtl/mld_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mld_pkg
// Brief   : Shared FSM encoding and (15,7) code defaults for the
//           majority-logic cyclic decoder.
// Rev     : 1.0
// ============================================================================
package mld_pkg;

    typedef enum logic [0:0] {
        ST_LOAD   = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

    // g(x) = x^8 + x^7 + x^6 + x^4 + 1, bit i = coefficient of x^i
    localparam logic [8:0]  C_DEF_GEN_POLY  = 9'h1D1;
    // Four syndrome-tap masks orthogonal on the highest-order bit
    localparam logic [31:0] C_DEF_CSUM_MASK = 32'h8045_2208;

endpackage
`default_nettype wire

// File: rtl/majority_gate_n.sv
`default_nettype none
// ============================================================================
// Module  : majority_gate_n
// Brief   : Threshold gate, asserts when more than J/2 of J inputs are set.
// Rev     : 1.0
// ============================================================================
module majority_gate_n #(
    parameter int J = 4
) (
    input  logic [J-1:0] i_bits,
    output logic         o_maj
);

    localparam int            CW     = $clog2(J + 1);
    localparam logic [CW-1:0] C_HALF = CW'(J / 2);

    logic [CW-1:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < J; i++) begin
            w_pop = w_pop + CW'(i_bits[i]);
        end
    end

    assign o_maj = (w_pop > C_HALF);

endmodule
`default_nettype wire

// File: rtl/mld_cyclic_decoder.sv
`default_nettype none
// ============================================================================
// Module  : mld_cyclic_decoder
// Brief   : Serial one-step majority-logic decoder for a cyclic (N,K) code.
// Rev     : 1.0
// ============================================================================
module mld_cyclic_decoder
    import mld_pkg::*;
#(
    parameter int                 N         = 15,
    parameter int                 K         = 7,
    parameter int                 J         = 4,
    parameter logic [N-K:0]       GEN_POLY  = C_DEF_GEN_POLY,
    parameter logic [J*(N-K)-1:0] CSUM_MASK = C_DEF_CSUM_MASK
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     abort,
    input  logic                     correct_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_bit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_bit,
    output logic                     out_info,
    output logic                     out_last,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic                     out_fail
);

    localparam int            R          = N - K;
    localparam int            CW         = $clog2(N);
    localparam int            EW         = $clog2(N + 1);
    localparam logic [CW-1:0] C_LAST     = CW'(N - 1);
    localparam logic [CW-1:0] C_INFO_END = CW'(K);
    localparam logic [EW-1:0] C_ERR_MAX  = EW'(N);

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_buf;
    logic [R-1:0]    r_syn;
    logic [CW-1:0]   r_cnt;
    logic [EW-1:0]   r_err;

    logic [J-1:0]    w_csum;
    logic            w_err_flag;
    logic            w_corr;
    logic            w_is_load;
    logic            w_is_dec;
    logic            w_load_fire;
    logic            w_dec_fire;
    logic            w_last;
    logic            w_shift_in;
    logic [R-1:0]    w_fb;
    logic [R-1:0]    w_syn_step;

    generate
        for (genvar j = 0; j < J; j++) begin : g_csum
            assign w_csum[j] = ^(r_syn & CSUM_MASK[j*R +: R]);
        end
    endgenerate

    majority_gate_n #(
        .J (J)
    ) u_majority (
        .i_bits (w_csum),
        .o_maj  (w_err_flag)
    );

    assign w_is_load   = (r_state == ST_LOAD);
    assign w_is_dec    = (r_state == ST_DECODE);
    assign w_load_fire = w_is_load & in_valid;
    assign w_dec_fire  = w_is_dec & out_ready;
    assign w_last      = (r_cnt == C_LAST);
    assign w_corr      = w_err_flag & correct_en;

    // One shared divide-by-g(x) step: received bits while loading,
    // the applied correction while cycling during decode.
    assign w_shift_in  = w_is_load ? in_bit : w_corr;
    assign w_fb        = {R{r_syn[R-1]}} & {GEN_POLY[R-1:1], 1'b1};
    assign w_syn_step  = {r_syn[R-2:0], w_shift_in} ^ w_fb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (in_valid && w_last)  w_state_next = ST_DECODE;
                ST_DECODE: if (out_ready && w_last) w_state_next = ST_LOAD;
                default:   w_state_next = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf <= '0;
            r_syn <= '0;
            r_cnt <= '0;
            r_err <= '0;
        end else if (abort) begin
            r_buf <= '0;
            r_syn <= '0;
            r_cnt <= '0;
            r_err <= '0;
        end else if (w_load_fire) begin
            r_buf <= {r_buf[N-2:0], in_bit};
            r_syn <= w_syn_step;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_err <= '0;
            end
        end else if (w_dec_fire) begin
            if (w_last) begin
                r_buf <= '0;
                r_syn <= '0;
                r_cnt <= '0;
            end else begin
                r_buf <= {r_buf[N-2:0], 1'b0};
                r_syn <= w_syn_step;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_corr && (r_err != C_ERR_MAX)) begin
                r_err <= r_err + EW'(1);
            end
        end
    end

    // The final residual is reported alongside the last bit, before it is cleared.
    always_comb begin
        in_ready  = w_is_load;
        out_valid = w_is_dec;
        out_bit   = w_is_dec & (r_buf[N-1] ^ w_corr);
        out_info  = w_is_dec & (r_cnt < C_INFO_END);
        out_last  = w_is_dec & w_last;
        out_fail  = w_is_dec & w_last & (|w_syn_step);
        err_count = r_err;
    end

endmodule
`default_nettype wire
